// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_pkg: shared types, default timing constants and width helper for the reset sequencer
package rst_seq_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, STABLE, RELEASE, RUN, HOLD, ACK} state_e;
  localparam int STAGE_NUM_DEF   = 4;
  localparam int LOCK_STABLE_DEF = 256;
  localparam int STAGE_DELAY_DEF = 150;
  localparam int HOLD_TIME_DEF   = 16;
  localparam int CNT_WIDTH_DEF   = 16;
  function automatic int idx_width(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int IDX_W_DEF = idx_width(STAGE_NUM_DEF);
endpackage

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: soft-reset handshake and sequenced reset outputs of the reset sequencer
interface rst_seq_ctrl_if #(parameter int pStageNum = 4);
  logic                 iSoftRstReq;
  logic                 oSoftRstAck;
  logic [pStageNum-1:0] oStageRst;
  logic                 oAllReady;
  modport master (output iSoftRstReq, input oSoftRstAck, oStageRst, oAllReady);
  modport slave  (input iSoftRstReq, output oSoftRstAck, oStageRst, oAllReady);
endinterface

// File: rtl/rst_seq_ctrl_sync.sv
// sync_ff2: generic two-flop synchronizer, async active-low reset to zero
module sync_ff2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  // first stage may go metastable, second stage hands a settled value to the core
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync_q, meta_q} <= '0;
    else        {sync_q, meta_q} <= {meta_q, d};
  assign q = sync_q;
endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: waits for stable PLL lock, then releases reset domains one by one
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int pStageNum   = STAGE_NUM_DEF,
  parameter int pLockStable = LOCK_STABLE_DEF,
  parameter int pStageDelay = STAGE_DELAY_DEF,
  parameter int pHoldTime   = HOLD_TIME_DEF,
  parameter int pCntWidth   = CNT_WIDTH_DEF
) (
  input  logic          iSysClk,
  input  logic          iSysRst,
  input  logic          iPllLock,
  rst_seq_ctrl_if.slave bus
);
  localparam int IDX_W = idx_width(pStageNum);
  localparam logic [pCntWidth-1:0] LOCK_LAST = pCntWidth'(pLockStable - 1);
  localparam logic [pCntWidth-1:0] REL_LAST  = pCntWidth'(pStageDelay - 1);
  localparam logic [pCntWidth-1:0] HOLD_LAST = pCntWidth'(pHoldTime - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(pStageNum - 1);
  state_e               state_q, state_d;
  logic [pCntWidth-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [pStageNum-1:0] stage_q, stage_d;
  logic                 ready_q, ready_d, ack_q, ack_d;
  logic                 s_lock, req, lost, lock_hit, rel_hit, hold_hit;
  sync_ff2 #(.W(1)) u_lock_sync (.clk(iSysClk), .rst_n(iSysRst), .d(iPllLock), .q(s_lock));
  assign req      = bus.iSoftRstReq;
  assign lost     = !s_lock && state_q != WAIT_LOCK;
  assign lock_hit = cnt_q == LOCK_LAST;
  assign rel_hit  = cnt_q == REL_LAST;
  assign hold_hit = cnt_q == HOLD_LAST;
  // state register plus all registered outputs and the shared delay counter
  always_ff @(posedge iSysClk or negedge iSysRst)
    if (!iSysRst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '1;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
    end
  // next state; lock loss overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: state_d = s_lock ? STABLE : WAIT_LOCK;
      STABLE:    state_d = lock_hit ? RELEASE : STABLE;
      RELEASE:   state_d = rel_hit && idx_q == IDX_LAST ? RUN : RELEASE;
      RUN:       state_d = req ? HOLD : RUN;
      HOLD:      state_d = hold_hit ? ACK : HOLD;
      ACK:       state_d = req ? ACK : RELEASE;
      default:   state_d = WAIT_LOCK;
    endcase
    if (lost) state_d = WAIT_LOCK;
  end
  // counter, stage index and output updates; the counter is always cleared on compare, never wrapped
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    ack_d   = ack_q;
    if (lost) begin
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '1;
      ready_d = 1'b0;
      ack_d   = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_d = '0;
          idx_d = '0;
        end
        STABLE: cnt_d = lock_hit ? '0 : cnt_q + pCntWidth'(1);
        RELEASE: begin
          cnt_d = rel_hit ? '0 : cnt_q + pCntWidth'(1);
          if (rel_hit) begin
            stage_d[idx_q] = 1'b0;
            idx_d          = idx_q + IDX_W'(1);
            ready_d        = idx_q == IDX_LAST;
          end
        end
        RUN:
          if (req) begin
            stage_d = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
          end
        HOLD: begin
          cnt_d = hold_hit ? '0 : cnt_q + pCntWidth'(1);
          ack_d = hold_hit;
        end
        ACK:
          if (!req) begin
            ack_d = 1'b0;
            cnt_d = '0;
            idx_d = '0;
          end
        default: ;
      endcase
    end
  end
  assign bus.oStageRst   = stage_q;
  assign bus.oAllReady   = ready_q;
  assign bus.oSoftRstAck = ack_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed stimulus with a queue scoreboard checking every output change
module tb_rst_seq_ctrl;
  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic       rdy;
    logic       ack;
  } exp_t;
  bit   clk;
  logic rst_n = 1'b0;
  logic lock  = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t;
  exp_t sbq[$];
  logic [5:0] prev = 'x;
  rst_seq_ctrl_if #(.pStageNum(4)) bus ();
  rst_seq_ctrl #(
    .pStageNum(4), .pLockStable(8), .pStageDelay(5), .pHoldTime(4), .pCntWidth(16)
  ) dut (
    .iSysClk(clk), .iSysRst(rst_n), .iPllLock(lock), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int c, input logic [3:0] s, input logic r, input logic a);
    sbq.push_back('{c, s, r, a});
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_seq(input int b);
    push(b + 16, 4'b1110, 1'b0, 1'b0);
    push(b + 21, 4'b1100, 1'b0, 1'b0);
    push(b + 26, 4'b1000, 1'b0, 1'b0);
    push(b + 31, 4'b0000, 1'b1, 1'b0);
  endtask
  always @(negedge clk) begin
    logic [5:0] cur;
    exp_t e;
    cur = {bus.oStageRst, bus.oAllReady, bus.oSoftRstAck};
    if (cur !== prev) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got st=%b rdy=%b ack=%b", cyc, cur[5:2], cur[1], cur[0]);
      end else begin
        e = sbq.pop_front();
        if ((e.cyc >= 0 && e.cyc != cyc) || cur !== {e.st, e.rdy, e.ack}) begin
          n_bad++;
          $display("FAIL output_change got cyc=%0d st=%b rdy=%b ack=%b want cyc=%0d st=%b rdy=%b ack=%b",
                   cyc, cur[5:2], cur[1], cur[0], e.cyc, e.st, e.rdy, e.ack);
        end
      end
    end
    prev = cur;
  end
  initial begin
    bus.iSoftRstReq = 1'b0;
    push(-1, 4'b1111, 1'b0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    t = cyc; lock = 1'b1; push_seq(t);
    tick(40);
    t = cyc; lock = 1'b0; push(t + 3, 4'b1111, 1'b0, 1'b0);
    tick(6);
    t = cyc; lock = 1'b1; push_seq(t);
    tick(40);
    t = cyc; bus.iSoftRstReq = 1'b1;
    push(t + 1, 4'b1111, 1'b0, 1'b0);
    push(t + 5, 4'b1111, 1'b0, 1'b1);
    tick(8);
    t = cyc; bus.iSoftRstReq = 1'b0;
    push(t + 1, 4'b1111, 1'b0, 1'b0);
    push(t + 6, 4'b1110, 1'b0, 1'b0);
    push(t + 11, 4'b1100, 1'b0, 1'b0);
    push(t + 16, 4'b1000, 1'b0, 1'b0);
    push(t + 21, 4'b0000, 1'b1, 1'b0);
    tick(30);
    t = cyc; lock = 1'b0; push(t + 3, 4'b1111, 1'b0, 1'b0);
    tick(6);
    t = cyc; lock = 1'b1;
    tick(4); lock = 1'b0;
    tick(6); lock = 1'b1;
    push_seq(t + 10);
    tick(50);
    t = cyc; lock = 1'b0; push(t + 3, 4'b1111, 1'b0, 1'b0);
    tick(6);
    t = cyc; lock = 1'b1;
    push(t + 16, 4'b1110, 1'b0, 1'b0);
    push(t + 21, 4'b1100, 1'b0, 1'b0);
    tick(23);
    push(cyc, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(2);
    t = cyc; rst_n = 1'b1; push_seq(t);
    tick(40);
    push(cyc, 4'b1111, 1'b0, 1'b0);
    rst_n = 1'b0; bus.iSoftRstReq = 1'b1;
    tick(2);
    t = cyc; rst_n = 1'b1; push_seq(t);
    push(t + 32, 4'b1111, 1'b0, 1'b0);
    push(t + 36, 4'b1111, 1'b0, 1'b1);
    tick(42);
    t = cyc; bus.iSoftRstReq = 1'b0;
    push(t + 1, 4'b1111, 1'b0, 1'b0);
    push(t + 6, 4'b1110, 1'b0, 1'b0);
    push(t + 11, 4'b1100, 1'b0, 1'b0);
    push(t + 16, 4'b1000, 1'b0, 1'b0);
    push(t + 21, 4'b0000, 1'b1, 1'b0);
    tick(30);
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_change got none want cyc=%0d st=%b rdy=%b ack=%b", e.cyc, e.st, e.rdy, e.ack);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
